// File: rtl/dc_timing_ctrl_if.sv
// Upstream pixel stream into the raster timing controller.
// The source drives pixel/valid; the controller pulls with ready.
interface dc_timing_ctrl_if;
  logic [23:0] src_pixel;
  logic        src_valid;
  logic        src_ready;

  modport master (
    output src_pixel,
    output src_valid,
    input  src_ready
  );

  modport slave (
    input  src_pixel,
    input  src_valid,
    output src_ready
  );
endinterface

// File: rtl/dc_timing_ctrl.sv
// Raster timing controller for the DC pixel interface: programmable h/v counters drive
// registered sync/data_valid strobes and pull pixels from an upstream valid/ready source.
module dc_timing_ctrl #(
  parameter int unsigned H_SYNC          = 5,
  parameter int unsigned H_BP            = 4,
  parameter int unsigned H_ACTIVE        = 16,
  parameter int unsigned H_FP            = 3,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 0,
  parameter int unsigned V_ACTIVE        = 4,
  parameter int unsigned V_FP            = 2,
  parameter logic [23:0] UNDERFLOW_PIXEL = 24'h0
) (
  input  logic                    dc_clk,
  input  logic                    dc_rst,
  input  logic                    en,
  dc_timing_ctrl_if.slave         src,
  output logic [23:0]             pixel_data,
  output logic                    data_valid,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    frame_done,
  output logic [15:0]             frame_cnt,
  output logic                    underflow,
  input  logic                    underflow_clr
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HSyncLast = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] HActStart = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] HActLast  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HOne      = HW'(1);
  localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VSyncLast = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] VActStart = VW'(V_BP);
  localparam logic [VW-1:0] VActLast  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VOne      = VW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d, h_rel;
  logic [VW-1:0] v_q, v_d, v_rel;
  logic          running, h_wrap, at_last, pos_active;

  logic [23:0]   pixel_q, pixel_d;
  logic          dv_q, dv_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          done_q, done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          underflow_q, underflow_d;

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    running     = (state_q != StIdle);
    h_wrap      = (h_q == HLast);
    at_last     = h_wrap && (v_q == VLast);
    // Offset-then-compare: positions before the window wrap to large values.
    h_rel       = h_q - HActStart;
    v_rel       = v_q - VActStart;
    pos_active  = running && (h_rel <= HActLast) && (v_rel <= VActLast);

    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StStop;
      StStop: begin
        if (en)           state_d = StRun;
        else if (at_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (running) begin
      h_d = h_wrap ? '0 : h_q + HOne;
      if (h_wrap) v_d = (v_q == VLast) ? '0 : v_q + VOne;
    end

    hsync_d     = running && (h_q <= HSyncLast);
    vsync_d     = running && (v_q <= VSyncLast);
    dv_d        = pos_active;
    done_d      = running && at_last;
    frame_cnt_d = (running && at_last) ? frame_cnt_q + 16'd1 : frame_cnt_q;

    pixel_d     = pixel_q;
    if (pos_active) pixel_d = src.src_valid ? src.src_pixel : UNDERFLOW_PIXEL;

    // A fresh underflow wins over a same-cycle clear.
    underflow_d = underflow_q;
    if (pos_active && !src.src_valid) underflow_d = 1'b1;
    else if (underflow_clr)           underflow_d = 1'b0;
  end

  always_ff @(posedge dc_clk or negedge dc_rst) begin
    if (!dc_rst) begin
      state_q     <= StIdle;
      h_q         <= '0;
      v_q         <= '0;
      pixel_q     <= '0;
      dv_q        <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      pixel_q     <= pixel_d;
      dv_q        <= dv_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign src.src_ready = pos_active;
  assign pixel_data    = pixel_q;
  assign data_valid    = dv_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign frame_done    = done_q;
  assign frame_cnt     = frame_cnt_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_dc_timing_ctrl.sv
// Scoreboard bench for dc_timing_ctrl: the source pushes expected pixels per handshake,
// a monitor pops on data_valid; directed windows check sync/strobe timing cycle by cycle.
module tb_dc_timing_ctrl;

  logic        dc_clk;
  logic        dc_rst;
  logic        en;
  logic        underflow_clr;
  logic [23:0] pixel_data;
  logic        data_valid;
  logic        hsync;
  logic        vsync;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        underflow;

  dc_timing_ctrl_if src_if ();

  dc_timing_ctrl u_dut (
    .dc_clk        (dc_clk),
    .dc_rst        (dc_rst),
    .en            (en),
    .src           (src_if),
    .pixel_data    (pixel_data),
    .data_valid    (data_valid),
    .hsync         (hsync),
    .vsync         (vsync),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  int          checks = 0;
  int          failures = 0;
  int          cur_k = -1;
  int          pop_cnt = 0;
  logic        clr_req = 1'b0;
  logic [23:0] exp_q[$];

  initial begin
    dc_clk = 1'b0;
    forever #5 dc_clk = ~dc_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog k=%0d act=timeout exp=finish", cur_k);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d act=%0h exp=%0h", name, cur_k, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 0);
    chk({tag, "_vsync"}, 32'(vsync), 0);
    chk({tag, "_dv"}, 32'(data_valid), 0);
    chk({tag, "_ready"}, 32'(src_if.src_ready), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
    chk({tag, "_uf"}, 32'(underflow), 0);
    chk({tag, "_pix"}, 32'(pixel_data), 0);
  endtask

  // Source: increments the pixel per accepted handshake; 67th and 84th ready cycles are
  // starved, and the 84th coincides with underflow_clr.
  initial begin
    logic [23:0] pix;
    int          next_idx;
    logic        rdy;
    logic        vld;
    pix = 24'h000001;
    next_idx = 1;
    src_if.src_pixel = pix;
    src_if.src_valid = 1'b1;
    underflow_clr = 1'b0;
    forever begin
      @(negedge dc_clk);
      rdy = src_if.src_ready;
      vld = src_if.src_valid;
      if (rdy) exp_q.push_back(vld ? src_if.src_pixel : 24'h0);
      @(posedge dc_clk);
      #2;
      if (rdy) begin
        next_idx++;
        if (vld) pix++;
      end
      src_if.src_pixel = pix;
      src_if.src_valid = !(next_idx == 67 || next_idx == 84);
      underflow_clr = clr_req || (next_idx == 84);
    end
  end

  // Monitor: every data_valid cycle must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge dc_clk);
      if (dc_rst && data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underrun k=%0d act=%0h exp=none", cur_k, pixel_data);
        end else begin
          chk("sb_pixel", 32'(pixel_data), 32'(exp_q.pop_front()));
          pop_cnt++;
        end
      end
    end
  end

  function automatic logic pos_active(input int q);
    int h;
    int v;
    h = q % 28;
    v = (q / 28) % 6;
    return (h >= 9) && (h < 25) && (v < 4);
  endfunction

  // Edge t is the one that samples en=1 from IDLE; check the k-th edge after it.
  task automatic window(input int phase, input int kmax, input int off_k, input int on_k,
                        input int idle_k, input int fbase);
    int   p;
    int   h;
    int   v;
    int   dv_cnt;
    logic idle;
    logic e_uf;
    dv_cnt = 0;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge dc_clk);
      #1;
      if (k == off_k) en = 1'b0;
      if (k == on_k) en = 1'b1;
      if (phase == 1) begin
        if (k == 195) clr_req = 1'b1;
        else if (k == 196) clr_req = 1'b0;
      end
      @(negedge dc_clk);
      cur_k = k;
      p = k - 1;
      h = p % 28;
      v = (p / 28) % 6;
      idle = (idle_k != 0) && (k > idle_k);
      if (phase == 1) e_uf = ((k >= 180) && (k < 196)) || (k >= 209);
      else e_uf = 1'b1;
      chk("hsync", 32'(hsync), idle ? 0 : 32'(h < 5));
      chk("vsync", 32'(vsync), idle ? 0 : 32'(v < 2));
      chk("data_valid", 32'(data_valid), idle ? 0 : 32'(pos_active(p)));
      chk("frame_done", 32'(frame_done), idle ? 0 : 32'((h == 27) && (v == 5)));
      chk("frame_cnt", 32'(frame_cnt), idle ? fbase + idle_k / 168 : fbase + k / 168);
      chk("src_ready", 32'(src_if.src_ready),
          ((idle_k != 0) && (k >= idle_k)) ? 0 : 32'(pos_active(k)));
      chk("underflow", 32'(underflow), 32'(e_uf));
      if (k <= 168 && data_valid) dv_cnt++;
    end
    cur_k = -1;
    if (phase == 1) chk("dv_per_frame", dv_cnt, 64);
  endtask

  initial begin
    dc_rst = 1'b0;
    en = 1'b0;
    #1;
    chk_zero("in_reset");
    repeat (3) @(posedge dc_clk);
    #1;
    dc_rst = 1'b1;
    repeat (5) begin
      @(negedge dc_clk);
      chk_zero("idle");
    end

    // Two frames free-running, en dropped mid second frame: finishes it, then IDLE.
    @(posedge dc_clk);
    #1;
    en = 1'b1;
    @(posedge dc_clk);
    window(1, 345, 220, 0, 336, 0);
    chk("sb_pops", pop_cnt, 128);
    chk("sb_empty", exp_q.size(), 0);

    // Restart; en low then high again during STOP, next frame follows without a gap.
    @(posedge dc_clk);
    #1;
    en = 1'b1;
    @(posedge dc_clk);
    window(2, 180, 50, 100, 0, 2);

    // Asynchronous reset in the middle of an active line.
    @(posedge dc_clk);
    #1;
    en = 1'b0;
    dc_rst = 1'b0;
    #1;
    chk_zero("mid_reset");
    exp_q.delete();
    @(posedge dc_clk);
    #1;
    dc_rst = 1'b1;
    repeat (4) begin
      @(negedge dc_clk);
      chk_zero("post_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
